a2d_scan_ctrl: RTL and testbench

Parametrised successor to the fixed four-channel A2D round-robin interface. It scans a configurable list of ADC channels over the existing SPI master (SPI_mnrch) and optionally averages 2^AVG_LOG2 samples per channel. It supports a single-scan mode triggered by nxt and a free-running continuous mode with a programmable inter-scan gap. It sits between the SPI pins of the external ADC and the sensor/balance logic, which consumes per-channel results.

---
 rtl/a2d_pkg.sv | 13 +
 rtl/a2d_scan_ctrl_spi.sv | 88 ++++++++
 rtl/a2d_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_a2d_scan_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D scan controller: FSM state encoding
// and the SPI command word layout expected by the external ADC.
package a2d_pkg;

  typedef enum logic [2:0] {IDLE, CMD, WAIT, READ, ACC, GAP} state_t;

  localparam logic [10:0] CMD_PAD = 11'h000;

  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, CMD_PAD};
  endfunction

endpackage

// File: rtl/a2d_scan_ctrl_spi.sv
// SPI_mnrch: 16-bit SPI master, SCLK = clk/16, idle high. MISO is sampled one
// clk before each SCLK rise, MOSI shifts on each SCLK fall.
module SPI_mnrch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic {S_IDLE, S_XFER} spi_state_t;

  spi_state_t  state_q, state_d;
  logic [3:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shft_q, shft_d;
  logic        smpl_q, smpl_d;
  logic        done_q, done_d;
  logic        ss_n_q, ss_n_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shft_q  <= '0;
      smpl_q  <= 1'b0;
      done_q  <= 1'b0;
      ss_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shft_q  <= shft_d;
      smpl_q  <= smpl_d;
      done_q  <= done_d;
      ss_n_q  <= ss_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shft_d  = shft_q;
    smpl_d  = smpl_q;
    done_d  = 1'b0;
    ss_n_d  = ss_n_q;
    case (state_q)
      S_IDLE: begin
        if (wrt) begin
          state_d = S_XFER;
          shft_d  = wt_data;
          div_d   = '0;
          bit_d   = '0;
          ss_n_d  = 1'b0;
        end
      end
      S_XFER: begin
        div_d = div_q + 4'd1;
        if (div_q == 4'd7) smpl_d = MISO;
        // Falling SCLK: shift out next MOSI bit and shift in the sampled MISO bit
        if (div_q == 4'd15) begin
          shft_d = {shft_q[14:0], smpl_q};
          bit_d  = bit_q + 4'd1;
          if (bit_q == 4'd15) begin
            state_d = S_IDLE;
            ss_n_d  = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign SCLK    = (state_q == S_XFER) ? div_q[3] : 1'b1;
  assign MOSI    = shft_q[15];
  assign SS_n    = ss_n_q;
  assign done    = done_q;
  assign rd_data = shft_q;

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Scans a configurable ADC channel list over SPI, averaging 2^AVG_LOG2 samples
// per slot, in single-shot (nxt) or continuous (cont, with idle gap) mode.
module a2d_scan_ctrl
  import a2d_pkg::*;
#(
  parameter int                    NUM_CH   = 4,
  parameter logic [NUM_CH*3-1:0]   CH_MAP   = {3'd6, 3'd5, 3'd4, 3'd0},
  parameter int                    DATA_W   = 12,
  parameter int                    AVG_LOG2 = 0,
  parameter int                    GAP_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     nxt,
  input  logic                     cont,
  input  logic [GAP_W-1:0]         gap,
  output logic [NUM_CH*DATA_W-1:0] rslt,
  output logic                     rslt_vld,
  output logic [2:0]               rslt_ch,
  output logic                     scan_done,
  output logic                     busy,
  output logic                     SS_n,
  output logic                     SCLK,
  output logic                     MOSI,
  input  logic                     MISO
);

  localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SMP_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam logic [SMP_W-1:0]  SMP_MAX   = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);

  state_t                    state_q, state_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [SMP_W-1:0]          smp_q, smp_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [NUM_CH*DATA_W-1:0]  rslt_q, rslt_d;
  logic                      rslt_vld_q, rslt_vld_d;
  logic [2:0]                rslt_ch_q, rslt_ch_d;
  logic                      scan_done_q, scan_done_d;
  logic                      busy_q, busy_d;

  logic                      spi_wrt;
  logic                      spi_done;
  logic [15:0]               spi_wdata;
  logic [15:0]               spi_rd;
  logic                      spi_rd_unused;

  function automatic logic [2:0] slot_addr(input logic [SLOT_W-1:0] s);
    slot_addr = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (s == SLOT_W'(i)) slot_addr = CH_MAP[3*i +: 3];
  endfunction

  // Truncating average: drop the AVG_LOG2 fraction bits of the sample sum.
  function automatic logic [DATA_W-1:0] avg_sample(input logic [ACC_W-1:0] a);
    return DATA_W'(a >> AVG_LOG2);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      smp_q       <= '0;
      acc_q       <= '0;
      gap_q       <= '0;
      rslt_q      <= '0;
      rslt_vld_q  <= 1'b0;
      rslt_ch_q   <= '0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      smp_q       <= smp_d;
      acc_q       <= acc_d;
      gap_q       <= gap_d;
      rslt_q      <= rslt_d;
      rslt_vld_q  <= rslt_vld_d;
      rslt_ch_q   <= rslt_ch_d;
      scan_done_q <= scan_done_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    smp_d       = smp_q;
    acc_d       = acc_q;
    gap_d       = gap_q;
    rslt_d      = rslt_q;
    rslt_vld_d  = 1'b0;
    rslt_ch_d   = rslt_ch_q;
    scan_done_d = 1'b0;
    busy_d      = busy_q;
    spi_wrt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (nxt || cont) begin
          state_d = CMD;
          spi_wrt = 1'b1;
          busy_d  = 1'b1;
        end
      end
      CMD: begin
        if (spi_done) state_d = WAIT;
      end
      // The ADC returns the conversion commanded by the previous transaction
      WAIT: begin
        spi_wrt = 1'b1;
        state_d = READ;
      end
      READ: begin
        if (spi_done) begin
          acc_d   = ((smp_q == '0) ? '0 : acc_q) + ACC_W'(spi_rd[DATA_W-1:0]);
          state_d = ACC;
        end
      end
      ACC: begin
        if (smp_q < SMP_MAX) begin
          smp_d   = smp_q + SMP_W'(1);
          state_d = CMD;
          spi_wrt = 1'b1;
        end else begin
          smp_d      = '0;
          rslt_vld_d = 1'b1;
          rslt_ch_d  = 3'(slot_q);
          for (int i = 0; i < NUM_CH; i++)
            if (slot_q == SLOT_W'(i)) rslt_d[DATA_W*i +: DATA_W] = avg_sample(acc_q);
          if (slot_q == SLOT_LAST) begin
            slot_d      = '0;
            scan_done_d = 1'b1;
            busy_d      = 1'b0;
            if (cont) begin
              state_d = GAP;
              gap_d   = gap;
            end else begin
              state_d = IDLE;
            end
          end else begin
            slot_d  = slot_q + SLOT_W'(1);
            state_d = CMD;
            spi_wrt = 1'b1;
          end
        end
      end
      // Stay gap cycles (at least one); dropping cont ends the gap at once
      GAP: begin
        if (!cont || gap_q <= GAP_W'(1)) state_d = IDLE;
        else                             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Command follows slot_d so a slot advance issues the new channel directly
  assign spi_wdata     = cmd_word(slot_addr(slot_d));
  assign spi_rd_unused = ^spi_rd;

  SPI_mnrch u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (spi_wrt),
    .wt_data (spi_wdata),
    .rd_data (spi_rd),
    .done    (spi_done),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  assign rslt      = rslt_q;
  assign rslt_vld  = rslt_vld_q;
  assign rslt_ch   = rslt_ch_q;
  assign scan_done = scan_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl: three instances (default, 4x averaging,
// six channels) each talking to a behavioural SPI ADC model.
module tb_a2d_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        nxt0 = 1'b0, nxt1 = 1'b0, nxt2 = 1'b0;
  logic        cont0 = 1'b0;
  logic [15:0] gap0 = 16'd0;
  logic [15:0] gap_z = 16'd0;
  logic        cont_z = 1'b0;

  logic [2:0]  ss_n, sclk, mosi, miso;
  logic [47:0] rslt0, rslt1;
  logic [71:0] rslt2;
  logic        vld0, vld1, vld2, done0, done1, done2, busy0, busy1, busy2;
  logic [2:0]  ch0, ch1, ch2;

  int          n_run = 0;
  int          n_fail = 0;
  int          w_vld, w_done, w_pre, w_sslow;
  logic [2:0]  chlog [16];

  always #5 clk = ~clk;

  a2d_scan_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .nxt(nxt0), .cont(cont0), .gap(gap0),
    .rslt(rslt0), .rslt_vld(vld0), .rslt_ch(ch0), .scan_done(done0), .busy(busy0),
    .SS_n(ss_n[0]), .SCLK(sclk[0]), .MOSI(mosi[0]), .MISO(miso[0]));

  a2d_scan_ctrl #(.AVG_LOG2(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .nxt(nxt1), .cont(cont_z), .gap(gap_z),
    .rslt(rslt1), .rslt_vld(vld1), .rslt_ch(ch1), .scan_done(done1), .busy(busy1),
    .SS_n(ss_n[1]), .SCLK(sclk[1]), .MOSI(mosi[1]), .MISO(miso[1]));

  a2d_scan_ctrl #(.NUM_CH(6), .CH_MAP({3'd2, 3'd1, 3'd6, 3'd5, 3'd4, 3'd0})) u_dut2 (
    .clk(clk), .rst_n(rst_n), .nxt(nxt2), .cont(cont_z), .gap(gap_z),
    .rslt(rslt2), .rslt_vld(vld2), .rslt_ch(ch2), .scan_done(done2), .busy(busy2),
    .SS_n(ss_n[2]), .SCLK(sclk[2]), .MOSI(mosi[2]), .MISO(miso[2]));

  // ADC reply loaded at SS_n fall: instance 1 returns 10,11,12,14 for the first
  // four conversions, everything else returns 12'h100 + last commanded address.
  function automatic logic [15:0] resp_for(input int k, input int n, input logic [2:0] a);
    if (k == 1 && n < 8) begin
      case (n / 2)
        0:       return 16'd10;
        1:       return 16'd11;
        2:       return 16'd12;
        default: return 16'd14;
      endcase
    end
    return 16'h0100 + 16'(a);
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_adc
    logic [15:0] tx_q = 16'h0;
    logic [15:0] rx_q = 16'h0;
    logic [15:0] resp_q = 16'h0;
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    logic [2:0]  addr_log [32];
    int          txn = 0;

    assign miso[k] = tx_q[15];

    always @(negedge clk) begin
      ss_prev   <= ss_n[k];
      sclk_prev <= sclk[k];
      if (ss_prev && !ss_n[k]) begin
        tx_q <= resp_q;
      end else if (!ss_n[k] && !sclk_prev && sclk[k]) begin
        rx_q <= {rx_q[14:0], mosi[k]};
        tx_q <= {tx_q[14:0], 1'b0};
      end
      if (!ss_prev && ss_n[k]) begin
        if (txn < 32) addr_log[txn] <= rx_q[13:11];
        resp_q <= resp_for(k, txn, rx_q[13:11]);
        txn    <= txn + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int w, output logic v, output logic d,
                        output logic [2:0] c, output logic s);
    case (w)
      0:       begin v = vld0; d = done0; c = ch0; s = ss_n[0]; end
      1:       begin v = vld1; d = done1; c = ch1; s = ss_n[1]; end
      default: begin v = vld2; d = done2; c = ch2; s = ss_n[2]; end
    endcase
  endtask

  task automatic pulse(input int w);
    @(negedge clk);
    case (w)
      0:       nxt0 = 1'b1;
      1:       nxt1 = 1'b1;
      default: nxt2 = 1'b1;
    endcase
    @(negedge clk);
    nxt0 = 1'b0; nxt1 = 1'b0; nxt2 = 1'b0;
  endtask

  // Observe one instance; w_pre counts SPI transactions that end before the
  // first rslt_vld, w_sslow counts cycles with SS_n low.
  task automatic watch(input int w, input int cycles, input bit stop);
    logic v, d, s, s_prev;
    logic [2:0] c;
    w_vld = 0; w_done = 0; w_pre = 0; w_sslow = 0;
    sample(w, v, d, c, s_prev);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      sample(w, v, d, c, s);
      if (!s) w_sslow++;
      if (!s_prev && s && w_vld == 0) w_pre++;
      s_prev = s;
      if (v) begin
        if (w_vld < 16) chlog[w_vld] = c;
        w_vld++;
      end
      if (d) begin
        w_done++;
        if (stop) break;
      end
    end
  endtask

  function automatic logic [47:0] chpack(input int n);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[3*i +: 3] = chlog[i];
    return r;
  endfunction

  task automatic gap_len(output int n);
    n = 0;
    while (ss_n[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ss(input logic lvl, input int max, input string tag);
    int n = 0;
    while (ss_n[0] !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) chk(tag, ss_n[0], lvl);
  endtask

  task automatic wait_vld_ch(input logic [2:0] c, input int max, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (vld0 && ch0 == c) found = 1'b1;
    end
    chk(tag, found, 1'b1);
  endtask

  localparam logic [47:0] EXP_DEF = {12'h106, 12'h105, 12'h104, 12'h100};

  initial begin
    int n;
    logic [17:0] addrs;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rslt", rslt0, 48'h0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_vld", vld0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_ss_n", ss_n[0], 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single scan, default map
    pulse(0);
    watch(0, 3000, 1'b1);
    chk("s1_done", w_done, 1);
    chk("s1_vld_cnt", w_vld, 4);
    chk("s1_ch_order", chpack(4), {3'd3, 3'd2, 3'd1, 3'd0});
    chk("s1_rslt", rslt0, EXP_DEF);
    chk("s1_busy_low", busy0, 1'b0);

    // 4x averaging: slot 0 = (10+11+12+14)>>2 = 11
    pulse(1);
    watch(1, 10000, 1'b1);
    chk("avg_txn_before_vld", w_pre, 8);
    chk("avg_done", w_done, 1);
    chk("avg_rslt", rslt1, {12'h106, 12'h105, 12'h104, 12'd11});

    // six channels
    pulse(2);
    watch(2, 4000, 1'b1);
    chk("six_done", w_done, 1);
    chk("six_ch_order", chpack(6), {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    chk("six_rslt", rslt2, {12'h102, 12'h101, 12'h106, 12'h105, 12'h104, 12'h100});
    addrs = '0;
    for (int i = 0; i < 6; i++) addrs[3*i +: 3] = g_adc[2].addr_log[2*i];
    chk("six_mosi_addr", addrs, {3'd2, 3'd1, 3'd6, 3'd5, 3'd4, 3'd0});
    pulse(2);
    watch(2, 4000, 1'b1);
    chk("six_wrap_first", chlog[0], 3'd0);
    chk("six_wrap_cnt", w_vld, 6);

    // continuous mode, gap = 20: scan_done to next SS_n fall is 20 GAP cycles plus IDLE
    @(negedge clk);
    gap0 = 16'd20;
    cont0 = 1'b1;
    watch(0, 3000, 1'b1);
    chk("cont_done1", w_done, 1);
    gap_len(n);
    chk("cont_gap20", n, 21);
    chk("cont_busy_restart", busy0, 1'b1);
    wait_vld_ch(3'd1, 3000, "cont_wait_slot1");
    cont0 = 1'b0;
    watch(0, 3000, 1'b1);
    chk("cont_drop_done", w_done, 1);
    chk("cont_drop_vld", w_vld, 2);
    watch(0, 800, 1'b0);
    chk("cont_drop_no_done", w_done, 0);
    chk("cont_drop_no_ss", w_sslow, 0);
    chk("cont_drop_busy", busy0, 1'b0);

    // nxt while busy is ignored
    pulse(0);
    repeat (300) @(negedge clk);
    pulse(0);
    watch(0, 3000, 1'b1);
    chk("busy_nxt_done", w_done, 1);
    chk("busy_nxt_vld", w_vld, 4);
    watch(0, 800, 1'b0);
    chk("busy_nxt_no_done", w_done, 0);
    chk("busy_nxt_no_ss", w_sslow, 0);

    // nxt and cont together: one scan, then continuous with gap 5
    @(negedge clk);
    gap0 = 16'd5;
    cont0 = 1'b1;
    nxt0 = 1'b1;
    @(negedge clk);
    nxt0 = 1'b0;
    watch(0, 3000, 1'b1);
    chk("both_done1", w_done, 1);
    gap_len(n);
    chk("both_gap5", n, 6);
    cont0 = 1'b0;
    watch(0, 3000, 1'b1);
    chk("both_done2", w_done, 1);
    chk("both_vld2", w_vld, 4);
    watch(0, 600, 1'b0);
    chk("both_no_ss", w_sslow, 0);

    // asynchronous reset during READ of slot 2
    pulse(0);
    wait_vld_ch(3'd1, 3000, "rst_wait_slot1");
    wait_ss(1'b1, 600, "rst_wait_cmd_end");
    wait_ss(1'b0, 50, "rst_wait_read_start");
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rslt", rslt0, 48'h0);
    chk("arst_busy", busy0, 1'b0);
    chk("arst_vld", vld0, 1'b0);
    chk("arst_done", done0, 1'b0);
    chk("arst_ch", ch0, 3'd0);
    chk("arst_ss_n", ss_n[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    pulse(0);
    watch(0, 3000, 1'b1);
    chk("arst_restart_done", w_done, 1);
    chk("arst_restart_first", chlog[0], 3'd0);
    chk("arst_restart_rslt", rslt0, EXP_DEF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
